memory_bus_arbiter: RTL and testbench
=====================================

Name: memory_bus_arbiter

Overview:
- Two-master arbiter for the core's single external memory bus (REQ/LOCK/ORDER/MASK/RW/ADDR/DATA, VALID/BUSY/64-bit DATA return).
- Shares that bus between the load/store unit (master 0) and the instruction fetch unit (master 1) using round-robin arbitration.
- Records which master issued each outstanding read, in issue order, and routes each read response back to that master.
- Sits between the core's fetch and LSU memory ports and the top-level oMEMORY_* / iMEMORY_* pins.

Parameters:
- P_OUTSTANDING_DEPTH, 4: maximum reads in flight. Must be a power of 2.
- P_OUTSTANDING_DEPTH_N, 2: log2(P_OUTSTANDING_DEPTH).

Ports:
- iCLOCK  in  1  single clock; all state is updated on its rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iM0_REQ / iM1_REQ  in  1  master request. The master holds the request until it sees its LOCK low.
- oM0_LOCK / oM1_LOCK  out  1  stall: the request is not accepted this cycle.
- iM0_ORDER / iM1_ORDER  in  2  access size: 0=byte, 1=2-byte, 2=word, 3=none.
- iM0_MASK / iM1_MASK  in  4  byte mask.
- iM0_RW / iM1_RW  in  1  1=write, 0=read.
- iM0_ADDR / iM1_ADDR  in  32  address.
- iM0_DATA / iM1_DATA  in  32  write data.
- oM0_VALID / oM1_VALID  out  1  read response valid.
- iM0_BUSY / iM1_BUSY  in  1  master cannot accept a response this cycle.
- oM0_DATA / oM1_DATA  out  64  read response data.
- oMEMORY_REQ  out  1  request to memory.
- iMEMORY_LOCK  in  1  memory stall.
- oMEMORY_ORDER  out  2
- oMEMORY_MASK  out  4
- oMEMORY_RW  out  1
- oMEMORY_ADDR  out  32
- oMEMORY_DATA  out  32
- iMEMORY_VALID  in  1  read response valid.
- oMEMORY_BUSY  out  1  response back-pressure to memory.
- iMEMORY_DATA  in  64  read response data.
- oPROTOCOL_ERR  out  1  sticky: memory returned VALID while no read was outstanding.

Behaviour:
- Reset (asynchronous, iRESET=1):
  - last-grant register = 1, so master 0 wins the first tie.
  - Tag FIFO empty; count = 0.
  - oPROTOCOL_ERR = 0.
  - All outputs are combinational from state and inputs. Under reset: oMEMORY_REQ=0, oM*_VALID=0, oMEMORY_BUSY=0.
  - Reset mid-operation drops all outstanding tags. Responses arriving after reset count as stray (see error rule below).
- Selection (combinational):
  - Only one master requesting: select it.
  - Both requesting: select the master that is not last-grant.
- Read block: rd_block = selected request is a read (RW=0) AND count == P_OUTSTANDING_DEPTH. The check is conservative and ignores a same-cycle pop.
- Forwarding:
  - oMEMORY_REQ = any request AND !rd_block.
  - ORDER, MASK, RW, ADDR and DATA are muxed from the selected master.
  - Zero-cycle pass-through; the arbiter adds no request latency.
- Accept: accept = oMEMORY_REQ AND !iMEMORY_LOCK.
  - oMx_LOCK = !(accept AND selected == x).
  - The non-selected master is always locked.
- On accept (clock edge):
  - last-grant <= selected.
  - If it is a read, push the selected master id into the tag FIFO.
  - Writes push nothing and get no response.
- Response routing:
  - The head tag h determines the destination.
  - oMh_VALID = iMEMORY_VALID AND !empty; oMh_DATA = iMEMORY_DATA.
  - The other master's VALID = 0. Both oM*_DATA carry iMEMORY_DATA.
  - oMEMORY_BUSY = !empty AND iMh_BUSY.
- Pop: pop = iMEMORY_VALID AND !empty AND !iMh_BUSY.
- Same-cycle push and pop: count is unchanged; write and read pointers both advance. Pointers wrap modulo depth.
- Stray response: iMEMORY_VALID while empty sets oPROTOCOL_ERR = 1 until reset. The data is dropped and no VALID is driven to either master.
- Responses are strictly in order. Reads from both masters interleave in issue order.
- Fairness: under continuous requests from both masters, grants alternate every accepted transfer. A locked or blocked cycle does not rotate the grant.

Decomposition:
- Shared package memory_bus_pkg:
  - ORDER encodings (L_ORDER_BYTE, L_ORDER_HALF, L_ORDER_WORD, L_ORDER_NONE).
  - L_RW_READ, L_RW_WRITE.
  - Master id constants L_MASTER_LSU = 0, L_MASTER_FETCH = 1.
- Sub-module memory_bus_arbiter_tag_fifo: 1-bit-wide synchronous FIFO of depth P_OUTSTANDING_DEPTH.
  - Push and pop ports; outputs full, empty, count and head.
  - Same asynchronous active-high reset as the arbiter.

Test Plan:
1. M0 read to 0x0002_0000 only, memory returns VALID with data 0x1122334455667788 two cycles later → M0 LOCK low for one cycle; oM0_VALID=1 with that data; oM1_VALID=0.
2. M0 and M1 both hold reads for 4 cycles, iMEMORY_LOCK=0 → grants M0, M1, M0, M1; responses A, B, C, D are routed to M0, M1, M0, M1 respectively.
3. Depth=4: M1 issues 5 reads with no response → 5th read held (oMEMORY_REQ=0, oM1_LOCK=1). One VALID then pops a tag, and the 5th read is accepted on the next cycle. A write from M0 issued while the FIFO is full is accepted immediately.
4. iMEMORY_LOCK=1 for 3 cycles with both masters requesting → no accept and no grant rotation; after release, the tie-winner is unchanged from before the lock.
5. Head owner M0 asserts iM0_BUSY=1 during VALID → oMEMORY_BUSY=1, no pop. After BUSY drops, a single VALID is delivered to M0 and count decrements by 1.
6. iMEMORY_VALID with FIFO empty → oPROTOCOL_ERR=1 and stays 1. Asserting iRESET mid-flight with 2 reads outstanding → count=0, oPROTOCOL_ERR=0, and a late VALID sets the error again.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// Shared encodings for the external memory bus and the two masters that share it.
// The arbiter, its tag FIFO and any bus-side logic import this package.
package memory_bus_pkg;

  localparam logic [1:0] L_ORDER_BYTE = 2'd0;
  localparam logic [1:0] L_ORDER_HALF = 2'd1;
  localparam logic [1:0] L_ORDER_WORD = 2'd2;
  localparam logic [1:0] L_ORDER_NONE = 2'd3;

  localparam logic L_RW_READ  = 1'b0;
  localparam logic L_RW_WRITE = 1'b1;

  localparam logic L_MASTER_LSU   = 1'b0;
  localparam logic L_MASTER_FETCH = 1'b1;

  // One master's request-side bus fields, grouped so the arbiter can mux them as a unit.
  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } memRequest_t;

endpackage

// File: rtl/memory_bus_arbiter_tag_fifo.sv
// In-order record of which master issued each outstanding read.
// Head is the owner of the next response; pointers wrap naturally since depth is a power of 2.
module memory_bus_arbiter_tag_fifo #(
  parameter int P_DEPTH   = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               iPUSH,
  input  logic               iPUSH_TAG,
  input  logic               iPOP,
  output logic               oFULL,
  output logic               oEMPTY,
  output logic [P_DEPTH_N:0] oCOUNT,
  output logic               oHEAD
);

  localparam logic [P_DEPTH_N:0]   L_DEPTH   = (P_DEPTH_N + 1)'(P_DEPTH);
  localparam logic [P_DEPTH_N:0]   L_CNT_ONE = (P_DEPTH_N + 1)'(1);
  localparam logic [P_DEPTH_N-1:0] L_PTR_ONE = (P_DEPTH_N)'(1);

  logic [P_DEPTH-1:0]   tagMem;
  logic [P_DEPTH_N-1:0] wrPtr;
  logic [P_DEPTH_N-1:0] rdPtr;
  logic [P_DEPTH_N:0]   count;
  logic                 doPush;
  logic                 doPop;

  assign oFULL  = (count == L_DEPTH);
  assign oEMPTY = (count == '0);
  assign oCOUNT = count;
  assign oHEAD  = tagMem[rdPtr];

  // Overflow and underflow are refused here so a misbehaving caller cannot corrupt the count.
  assign doPush = iPUSH && !oFULL;
  assign doPop  = iPOP && !oEMPTY;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      tagMem <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
    end else begin
      if (doPush) begin
        tagMem[wrPtr] <= iPUSH_TAG;
        wrPtr         <= wrPtr + L_PTR_ONE;
      end
      if (doPop) begin
        rdPtr <= rdPtr + L_PTR_ONE;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + L_CNT_ONE;
        2'b01:   count <= count - L_CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing the external memory bus between the LSU (master 0)
// and instruction fetch (master 1); read responses are routed back in issue order.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int P_OUTSTANDING_DEPTH   = 4,
  parameter int P_OUTSTANDING_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iM0_REQ,
  output logic        oM0_LOCK,
  input  logic [1:0]  iM0_ORDER,
  input  logic [3:0]  iM0_MASK,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [63:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_LOCK,
  input  logic [1:0]  iM1_ORDER,
  input  logic [3:0]  iM1_MASK,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [63:0] oM1_DATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_BUSY,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oPROTOCOL_ERR
);

  // Handshakes: a request transfers on a cycle where REQ=1 and LOCK=0 (the requester
  // holds REQ and its fields stable until then); a response transfers on a cycle where
  // VALID=1 and BUSY=0 (the responder holds VALID and DATA until then).

  localparam logic [P_OUTSTANDING_DEPTH_N:0] L_DEPTH =
    (P_OUTSTANDING_DEPTH_N + 1)'(P_OUTSTANDING_DEPTH);

  memRequest_t m0Bus;
  memRequest_t m1Bus;
  memRequest_t selBus;

  logic                           lastGrant;
  logic                           selMaster;
  logic                           anyReq;
  logic                           rdBlock;
  logic                           accept;
  logic                           pushTag;
  logic                           popTag;
  logic                           headTag;
  logic                           headBusy;
  logic                           fifoFull;
  logic                           fifoEmpty;
  logic [P_OUTSTANDING_DEPTH_N:0] fifoCount;
  logic                           errSticky;

  assign m0Bus = '{order: iM0_ORDER, mask: iM0_MASK, rw: iM0_RW, addr: iM0_ADDR, data: iM0_DATA};
  assign m1Bus = '{order: iM1_ORDER, mask: iM1_MASK, rw: iM1_RW, addr: iM1_ADDR, data: iM1_DATA};

  // On a tie the master that did not win last time goes next.
  always_comb begin
    selMaster = L_MASTER_LSU;
    if (iM0_REQ && iM1_REQ) begin
      selMaster = ~lastGrant;
    end else if (iM1_REQ) begin
      selMaster = L_MASTER_FETCH;
    end
  end

  assign selBus = (selMaster == L_MASTER_FETCH) ? m1Bus : m0Bus;
  assign anyReq = iM0_REQ || iM1_REQ;

  // Conservative: a response popping a tag this same cycle does not unblock the read.
  assign rdBlock = (selBus.rw == L_RW_READ) && (fifoCount == L_DEPTH);

  assign oMEMORY_REQ   = anyReq && !rdBlock && !iRESET;
  assign oMEMORY_ORDER = selBus.order;
  assign oMEMORY_MASK  = selBus.mask;
  assign oMEMORY_RW    = selBus.rw;
  assign oMEMORY_ADDR  = selBus.addr;
  assign oMEMORY_DATA  = selBus.data;

  assign accept   = oMEMORY_REQ && !iMEMORY_LOCK;
  assign oM0_LOCK = !(accept && (selMaster == L_MASTER_LSU));
  assign oM1_LOCK = !(accept && (selMaster == L_MASTER_FETCH));

  assign pushTag = accept && (selBus.rw == L_RW_READ) && !fifoFull;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      lastGrant <= L_MASTER_FETCH;
    end else if (accept) begin
      lastGrant <= selMaster;
    end
  end

  memory_bus_arbiter_tag_fifo #(
    .P_DEPTH  (P_OUTSTANDING_DEPTH),
    .P_DEPTH_N(P_OUTSTANDING_DEPTH_N)
  ) u_tag_fifo (
    .iCLOCK   (iCLOCK),
    .iRESET   (iRESET),
    .iPUSH    (pushTag),
    .iPUSH_TAG(selMaster),
    .iPOP     (popTag),
    .oFULL    (fifoFull),
    .oEMPTY   (fifoEmpty),
    .oCOUNT   (fifoCount),
    .oHEAD    (headTag)
  );

  // Response side: the head tag names the owner; with no tag the response is stray.
  assign headBusy     = (headTag == L_MASTER_FETCH) ? iM1_BUSY : iM0_BUSY;
  assign oM0_VALID    = iMEMORY_VALID && !fifoEmpty && (headTag == L_MASTER_LSU);
  assign oM1_VALID    = iMEMORY_VALID && !fifoEmpty && (headTag == L_MASTER_FETCH);
  assign oM0_DATA     = iMEMORY_DATA;
  assign oM1_DATA     = iMEMORY_DATA;
  assign oMEMORY_BUSY = !fifoEmpty && headBusy;
  assign popTag       = iMEMORY_VALID && !fifoEmpty && !headBusy;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      errSticky <= 1'b0;
    end else if (iMEMORY_VALID && fifoEmpty) begin
      errSticky <= 1'b1;
    end
  end

  assign oPROTOCOL_ERR = errSticky;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Randomized and directed bench for memory_bus_arbiter against a queue-based reference model.
// Expected read data is queued per master at issue; a monitor pops it when the DUT delivers.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mReq   [2];
  logic        mRw    [2];
  logic        mBusy  [2];
  logic [1:0]  mOrder [2];
  logic [3:0]  mMask  [2];
  logic [31:0] mAddr  [2];
  logic [31:0] mData  [2];
  logic [63:0] mRdata [2];
  logic        memLock;
  logic        memValid;
  logic [63:0] memData;

  logic        oM0_LOCK, oM1_LOCK, oM0_VALID, oM1_VALID;
  logic [63:0] oM0_DATA, oM1_DATA;
  logic        oMEMORY_REQ, oMEMORY_RW, oMEMORY_BUSY, oPROTOCOL_ERR;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic [31:0] oMEMORY_ADDR, oMEMORY_DATA;

  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  logic [63:0] slaveQ[$];
  int          tags[$];
  int          mLast;
  bit          mErr;
  bit          accDone[2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(.P_OUTSTANDING_DEPTH(4), .P_OUTSTANDING_DEPTH_N(2)) dut (
    .iCLOCK(clk), .iRESET(rst),
    .iM0_REQ(mReq[0]), .oM0_LOCK(oM0_LOCK), .iM0_ORDER(mOrder[0]), .iM0_MASK(mMask[0]),
    .iM0_RW(mRw[0]), .iM0_ADDR(mAddr[0]), .iM0_DATA(mData[0]),
    .oM0_VALID(oM0_VALID), .iM0_BUSY(mBusy[0]), .oM0_DATA(oM0_DATA),
    .iM1_REQ(mReq[1]), .oM1_LOCK(oM1_LOCK), .iM1_ORDER(mOrder[1]), .iM1_MASK(mMask[1]),
    .iM1_RW(mRw[1]), .iM1_ADDR(mAddr[1]), .iM1_DATA(mData[1]),
    .oM1_VALID(oM1_VALID), .iM1_BUSY(mBusy[1]), .oM1_DATA(oM1_DATA),
    .oMEMORY_REQ(oMEMORY_REQ), .iMEMORY_LOCK(memLock), .oMEMORY_ORDER(oMEMORY_ORDER),
    .oMEMORY_MASK(oMEMORY_MASK), .oMEMORY_RW(oMEMORY_RW), .oMEMORY_ADDR(oMEMORY_ADDR),
    .oMEMORY_DATA(oMEMORY_DATA), .iMEMORY_VALID(memValid), .oMEMORY_BUSY(oMEMORY_BUSY),
    .iMEMORY_DATA(memData), .oPROTOCOL_ERR(oPROTOCOL_ERR)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frontData();
    return (slaveQ.size() > 0) ? slaveQ[0] : 64'h0;
  endfunction

  // Reference model: evaluated mid-cycle with inputs stable, then advanced to the next edge.
  always @(negedge clk) begin
    int sel, n, h;
    bit eReq, eAcc, ePop, eBusy, blk;
    bit [1:0] eV;
    if (rst) begin
      chk("reset req", oMEMORY_REQ, 0);
      chk("reset valid", {oM0_VALID, oM1_VALID}, 0);
      chk("reset busy", oMEMORY_BUSY, 0);
      chk("reset err", oPROTOCOL_ERR, 0);
      tags.delete(); slaveQ.delete(); exp_q0.delete(); exp_q1.delete();
      mLast = 1; mErr = 0; accDone[0] = 0; accDone[1] = 0;
    end else begin
      n = tags.size();
      if (mReq[0] && mReq[1]) sel = 1 - mLast;
      else if (mReq[1]) sel = 1;
      else sel = 0;
      blk  = (mRw[sel] == 1'b0) && (n == 4);
      eReq = (mReq[0] || mReq[1]) && !blk;
      eAcc = eReq && !memLock;
      eV = 2'b00; eBusy = 0; ePop = 0;
      if (n > 0) begin
        h = tags[0];
        eBusy = mBusy[h];
        if (memValid) begin
          eV[h] = 1'b1;
          ePop = !mBusy[h];
        end
      end
      chk("mem req", oMEMORY_REQ, eReq);
      chk("m0 lock", oM0_LOCK, !(eAcc && sel == 0));
      chk("m1 lock", oM1_LOCK, !(eAcc && sel == 1));
      chk("m0 valid", oM0_VALID, eV[0]);
      chk("m1 valid", oM1_VALID, eV[1]);
      chk("mem busy", oMEMORY_BUSY, eBusy);
      chk("protocol err", oPROTOCOL_ERR, mErr);
      if (eReq)
        chk("forward", {oMEMORY_ORDER, oMEMORY_MASK, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA},
            {mOrder[sel], mMask[sel], mRw[sel], mAddr[sel], mData[sel]});
      if (memValid) chk("resp data", {oM0_DATA, oM1_DATA}, {memData, memData});
      accDone[0] = mReq[0] && !oM0_LOCK;
      accDone[1] = mReq[1] && !oM1_LOCK;
      if (ePop) begin
        void'(tags.pop_front());
        void'(slaveQ.pop_front());
      end
      if (eAcc) begin
        mLast = sel;
        if (mRw[sel] == 1'b0) begin
          tags.push_back(sel);
          slaveQ.push_back(mRdata[sel]);
          if (sel == 0) exp_q0.push_back(mRdata[0]);
          else exp_q1.push_back(mRdata[1]);
        end
      end
      if (memValid && n == 0) mErr = 1;
    end
  end

  // Monitor: every delivered response must be the oldest one expected by that master.
  always @(negedge clk) begin
    if (!rst) begin
      if (oM0_VALID && !mBusy[0]) begin
        if (exp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL m0 unexpected response: got %0h expected none", oM0_DATA);
        end else chk("m0 data", oM0_DATA, exp_q0.pop_front());
      end
      if (oM1_VALID && !mBusy[1]) begin
        if (exp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL m1 unexpected response: got %0h expected none", oM1_DATA);
        end else chk("m1 data", oM1_DATA, exp_q1.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      mReq[m] = 0; mBusy[m] = 0; mRw[m] = 0; mOrder[m] = 0; mMask[m] = 0;
      mAddr[m] = 0; mData[m] = 0; mRdata[m] = 0;
    end
    memLock = 0; memValid = 0; memData = 0;
  endtask

  task automatic newReq(input int m, input bit rw, input logic [31:0] addr);
    mReq[m] = 1; mRw[m] = rw; mAddr[m] = addr; mData[m] = $urandom;
    mOrder[m] = 2'($urandom_range(0, 3)); mMask[m] = 4'($urandom_range(0, 15));
    mRdata[m] = {$urandom, $urandom};
  endtask

  task automatic doReset();
    idle();
    rst = 1; cyc(); cyc();
    rst = 0; cyc();
  endtask

  task automatic drain();
    mReq[0] = 0; mReq[1] = 0; mBusy[0] = 0; mBusy[1] = 0; memLock = 0;
    for (int i = 0; i < 64 && slaveQ.size() > 0; i++) begin
      memValid = 1; memData = frontData(); cyc();
    end
    memValid = 0; cyc();
    chk("drain complete", slaveQ.size(), 0);
  endtask

  initial begin
    rst = 1;
    idle();
    cyc();

    // Single M0 read with a response two cycles after acceptance.
    doReset();
    newReq(0, 0, 32'h0002_0000); mRdata[0] = 64'h1122_3344_5566_7788;
    cyc(); mReq[0] = 0;
    cyc();
    memValid = 1; memData = frontData(); cyc();
    memValid = 0; cyc();

    // Both masters streaming reads: grants alternate starting with M0.
    doReset();
    newReq(0, 0, $urandom); newReq(1, 0, $urandom);
    for (int i = 0; i < 4; i++) begin
      cyc();
      for (int m = 0; m < 2; m++) if (accDone[m]) newReq(m, 0, $urandom);
    end
    drain();

    // Fill the tag FIFO from M1, then a write from M0 still passes; one pop frees the 5th read.
    doReset();
    newReq(1, 0, $urandom);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (accDone[1]) newReq(1, 0, $urandom);
    end
    newReq(0, 1, $urandom);
    cyc(); mReq[0] = 0;
    memValid = 1; memData = frontData(); cyc();
    memValid = 0; cyc();
    mReq[1] = 0;
    drain();

    // Memory stall with both requesting must not rotate the grant.
    doReset();
    memLock = 1; newReq(0, 0, $urandom); newReq(1, 0, $urandom);
    repeat (3) cyc();
    memLock = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      for (int m = 0; m < 2; m++) if (accDone[m]) newReq(m, 0, $urandom);
    end
    drain();

    // Head owner back-pressure holds the response.
    doReset();
    newReq(0, 0, $urandom);
    cyc(); mReq[0] = 0;
    mBusy[0] = 1; memValid = 1; memData = frontData(); cyc(); cyc();
    mBusy[0] = 0; cyc();
    memValid = 0; cyc();
    drain();

    // Stray response, then reset with reads in flight and a late response.
    doReset();
    memValid = 1; memData = {$urandom, $urandom}; cyc();
    memValid = 0; repeat (3) cyc();
    newReq(0, 0, $urandom); cyc();
    newReq(0, 0, $urandom); cyc();
    mReq[0] = 0;
    rst = 1; cyc();
    rst = 0; cyc();
    memValid = 1; memData = {$urandom, $urandom}; cyc();
    memValid = 0; repeat (2) cyc();

    // Random traffic with random stalls and back-pressure.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!mReq[m] || accDone[m]) begin
          if ($urandom_range(0, 9) < 6) newReq(m, $urandom_range(0, 9) < 3, $urandom);
          else mReq[m] = 0;
        end
        mBusy[m] = ($urandom_range(0, 3) == 0);
      end
      memLock  = ($urandom_range(0, 3) == 0);
      memValid = (slaveQ.size() > 0) && ($urandom_range(0, 1) == 1);
      memData  = memValid ? frontData() : {$urandom, $urandom};
      cyc();
    end
    drain();
    chk("m0 leftover", exp_q0.size(), 0);
    chk("m1 leftover", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
